// File: rtl/acl_motion_sampler_pkg.sv
// -----------------------------------------------------------------------------
// acl_motion_sampler_pkg
// Shared types and constants for the accelerometer motion sampler.
//   SAMPLE_W : width of the magnitude-squared sample (x^2+y^2+z^2)
//   HIT_W    : width of the consecutive-exceedance counter (HITS <= 15)
//   state_e  : sequencer states
//   abs_diff : unsigned absolute difference of two samples
// -----------------------------------------------------------------------------
package acl_motion_sampler_pkg;

  localparam int unsigned SAMPLE_W = 24;
  localparam int unsigned HIT_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // waiting for a pending tick and a ready sensor
    ST_WAIT = 2'd1,  // fetch issued, waiting for the sample strobe
    ST_EVAL = 2'd2   // one-cycle delta comparison against the previous sample
  } state_e;

  // Both operands are unsigned and the same width, so the smaller is always
  // subtracted from the larger and the result cannot wrap.
  function automatic logic [SAMPLE_W-1:0] abs_diff(input logic [SAMPLE_W-1:0] a,
                                                    input logic [SAMPLE_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/acl_tick_gen.sv
// -----------------------------------------------------------------------------
// acl_tick_gen
// Free-running sample-period counter. Counts 0..PERIOD-1 while enabled and
// emits a one-cycle tick on the wrap cycle. Dropping enable parks the counter
// at 0 so the first tick after re-enable is a full period away.
// Ports:
//   clk_i     : system clock
//   rst_i     : synchronous active-high reset
//   enable_i  : count enable
//   tick_o    : one-cycle pulse when the counter wraps
// -----------------------------------------------------------------------------
module acl_tick_gen #(
  parameter int unsigned PERIOD = 1000000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap;

  assign wrap = (cnt_q == CW'(PERIOD - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!enable_i || wrap) cnt_d = '0;
    else                   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign tick_o = enable_i & wrap;

endmodule

// File: rtl/acl_motion_sampler.sv
// -----------------------------------------------------------------------------
// acl_motion_sampler
// Sequencing controller for the SPI accelerometer front end. Issues a fetch
// request every PERIOD cycles, captures the returned magnitude-squared sample,
// and raises a sticky motion alarm after HITS consecutive sample-to-sample
// deltas strictly above the threshold. A fetch that is not answered within
// TIMEOUT cycles raises a sticky fault.
// Ports:
//   clk_i          : system clock
//   rst_i          : synchronous active-high reset
//   enable_i       : sampling enable
//   threshold_i    : unsigned delta threshold
//   clear_i        : level clear of alarm_o and fault_o (a same-cycle set wins)
//   acl_ready_i    : accelerometer interface idle/configured
//   acl_fetch_o    : one-cycle fetch request
//   acl_arrived_i  : one-cycle sample-valid strobe
//   acl_acc_i      : sample value, valid with acl_arrived_i
//   sample_o       : last captured sample
//   sample_valid_o : one-cycle strobe, sample_o updated
//   alarm_o        : sticky motion alarm
//   fault_o        : sticky timeout fault
// -----------------------------------------------------------------------------
module acl_motion_sampler
  import acl_motion_sampler_pkg::*;
#(
  parameter int unsigned PERIOD  = 1000000,
  parameter int unsigned TIMEOUT = 65536,
  parameter int unsigned HITS    = 3
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enable_i,
  input  logic [SAMPLE_W-1:0] threshold_i,
  input  logic                clear_i,
  input  logic                acl_ready_i,
  output logic                acl_fetch_o,
  input  logic                acl_arrived_i,
  input  logic [SAMPLE_W-1:0] acl_acc_i,
  output logic [SAMPLE_W-1:0] sample_o,
  output logic                sample_valid_o,
  output logic                alarm_o,
  output logic                fault_o
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_e              state_q;
  logic [TW-1:0]       timer_q;
  logic                pending_q;
  logic                have_prev_q;
  logic                flush_q;
  logic [HIT_W-1:0]    hit_cnt_q, hit_cnt_d;
  logic [SAMPLE_W-1:0] prev_q;
  logic [SAMPLE_W-1:0] sample_q;
  logic                sample_valid_q;
  logic                fetch_q;
  logic                alarm_q;
  logic                fault_q;

  logic                tick;
  logic                fetch_go;
  logic [SAMPLE_W-1:0] delta;
  logic                is_hit;

  acl_tick_gen #(
    .PERIOD (PERIOD)
  ) u_tick (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .enable_i (enable_i),
    .tick_o   (tick)
  );

  assign fetch_go = (state_q == ST_IDLE) && pending_q && enable_i && acl_ready_i;

  // Exceedance evaluation, used only in ST_EVAL. The first sample after a
  // reset or an enable drop has nothing to compare against and never hits.
  always_comb begin
    delta     = abs_diff(sample_q, prev_q);
    is_hit    = have_prev_q && (delta > threshold_i);
    hit_cnt_d = '0;
    if (is_hit) begin
      if (hit_cnt_q >= HIT_W'(HITS)) hit_cnt_d = HIT_W'(HITS);
      else                           hit_cnt_d = hit_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= ST_IDLE;
      timer_q        <= '0;
      pending_q      <= 1'b0;
      have_prev_q    <= 1'b0;
      flush_q        <= 1'b0;
      hit_cnt_q      <= '0;
      prev_q         <= '0;
      sample_q       <= '0;
      sample_valid_q <= 1'b0;
      fetch_q        <= 1'b0;
      alarm_q        <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      fetch_q        <= 1'b0;
      sample_valid_q <= 1'b0;

      // Clear first; any set further down in this block overrides it.
      if (clear_i) begin
        alarm_q <= 1'b0;
        fault_q <= 1'b0;
      end

      // Remember that enable dropped so the comparison history is discarded
      // once any in-flight transaction has finished.
      if (!enable_i) flush_q <= 1'b1;

      // A single pending slot: extra ticks while it is set are absorbed, and
      // a tick landing on the fetch cycle is absorbed by that fetch.
      if (!enable_i || fetch_go) pending_q <= 1'b0;
      else if (tick)             pending_q <= 1'b1;

      case (state_q)
        ST_IDLE: begin
          if (flush_q || !enable_i) begin
            have_prev_q <= 1'b0;
            hit_cnt_q   <= '0;
            flush_q     <= 1'b0;
          end
          if (fetch_go) begin
            fetch_q <= 1'b1;
            timer_q <= '0;
            state_q <= ST_WAIT;
          end
        end

        ST_WAIT: begin
          if (acl_arrived_i) begin
            sample_q       <= acl_acc_i;
            sample_valid_q <= 1'b1;
            state_q        <= ST_EVAL;
          end else if (timer_q == TW'(TIMEOUT - 1)) begin
            // Hung transaction: no sample, comparison history untouched.
            fault_q <= 1'b1;
            state_q <= ST_IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end

        ST_EVAL: begin
          hit_cnt_q <= hit_cnt_d;
          if (hit_cnt_d == HIT_W'(HITS)) alarm_q <= 1'b1;
          prev_q      <= sample_q;
          have_prev_q <= 1'b1;
          state_q     <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign acl_fetch_o    = fetch_q;
  assign sample_o       = sample_q;
  assign sample_valid_o = sample_valid_q;
  assign alarm_o        = alarm_q;
  assign fault_o        = fault_q;

endmodule

// File: tb/tb_acl_motion_sampler.sv
// -----------------------------------------------------------------------------
// tb_acl_motion_sampler
// Self-checking bench for acl_motion_sampler (PERIOD=16, TIMEOUT=32, HITS=3).
// Expected alarm state comes from a sample-history model: each captured sample
// is compared with the previous one, the hit flags are kept in a queue, and
// the alarm is due whenever the trailing run of hits reaches HITS.
// -----------------------------------------------------------------------------
module tb_acl_motion_sampler;

  localparam int PER = 16;
  localparam int TMO = 32;
  localparam int NH  = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en  = 1'b0;
  logic        clr = 1'b0;
  logic        rdy = 1'b1;
  logic        arr = 1'b0;
  logic [23:0] thr = '0;
  logic [23:0] acc = '0;
  logic        fetch, svld, alarm, fault;
  logic [23:0] smp;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // reference model state
  bit          have;
  logic [23:0] prev_v;
  bit          hits[$];
  bit          exp_alarm;
  int          last_f;

  acl_motion_sampler #(
    .PERIOD  (PER),
    .TIMEOUT (TMO),
    .HITS    (NH)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .enable_i       (en),
    .threshold_i    (thr),
    .clear_i        (clr),
    .acl_ready_i    (rdy),
    .acl_fetch_o    (fetch),
    .acl_arrived_i  (arr),
    .acl_acc_i      (acc),
    .sample_o       (smp),
    .sample_valid_o (svld),
    .alarm_o        (alarm),
    .fault_o        (fault)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_push(input logic [23:0] v);
    int dd;
    int run;
    if (have) begin
      dd = int'(v) - int'(prev_v);
      if (dd < 0) dd = -dd;
      hits.push_back(dd > int'(thr));
    end
    prev_v = v;
    have   = 1'b1;
    run = 0;
    for (int i = hits.size() - 1; i >= 0 && hits[i]; i--) run++;
    if (run >= NH) exp_alarm = 1'b1;
  endtask

  task automatic model_flush();
    hits.delete();
    have   = 1'b0;
    last_f = -1;
  endtask

  task automatic wait_fetch(input int bound, output int f);
    f = -1;
    for (int i = 0; i < bound; i++) begin
      if (fetch === 1'b1) begin
        f = cyc;
        break;
      end
      @(negedge clk);
    end
    if (f < 0) chk("fetch_seen", fetch, 1);
  endtask

  task automatic count_fetch(input int n, output int c);
    c = 0;
    repeat (n) begin
      @(negedge clk);
      if (fetch === 1'b1) c++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; clr = 1'b0; rdy = 1'b1; arr = 1'b0; acc = '0;
    repeat (2) @(negedge clk);
    chk("rst_fetch", fetch, 0);
    chk("rst_vld",   svld,  0);
    chk("rst_smp",   smp,   0);
    chk("rst_alarm", alarm, 0);
    chk("rst_fault", fault, 0);
    rst = 1'b0;
    exp_alarm = 1'b0;
    model_flush();
  endtask

  // One responder transaction: wait for the fetch, answer d cycles later with
  // v, then check capture, latency and the model's alarm.
  task automatic xact(input logic [23:0] v, input int d, input bit do_clr, input bit drop_en);
    int f;
    wait_fetch(40, f);
    if (f < 0) return;
    if (last_f >= 0) chk("cadence", f - last_f, PER);
    last_f = f;
    if (do_clr) exp_alarm = 1'b0;
    for (int k = 0; k <= d; k++) begin
      clr = do_clr && (k == 0);
      if (drop_en && k == 0) en = 1'b0;
      if (k == d) begin
        chk("vld_pre", svld, 0);
        arr = 1'b1;
        acc = v;
      end
      @(negedge clk);
      clr = 1'b0;
      arr = 1'b0;
    end
    chk("vld",       svld,  1);
    chk("sample",    smp,   v);
    chk("alarm_lat", alarm, exp_alarm);
    model_push(v);
    @(negedge clk);
    chk("vld_clr", svld,  0);
    chk("alarm",   alarm, exp_alarm);
    chk("fault",   fault, 0);
  endtask

  int alarm_seq[6] = '{1000, 1000, 5000, 1000, 5000, 1000};
  int ncons_seq[8] = '{1000, 5000, 5000, 9000, 9000, 12000, 15000, 18000};

  initial begin
    int f, c, c1, c2;
    @(negedge clk);
    do_reset();

    // basic cadence, threshold at max so no hits
    thr = 24'hFFFFFF; en = 1'b1;
    for (int i = 0; i < 6; i++) xact(24'($urandom), 5, 1'b0, 1'b0);

    // alarm after three consecutive exceedances
    do_reset();
    thr = 24'd3000; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      xact(24'(alarm_seq[i]), 5, 1'b0, 1'b0);
      if (i == 3) chk("no_alarm_early", alarm, 0);
    end
    chk("alarm_hold", alarm, 1);

    // non-consecutive hits, and delta equal to threshold is not a hit
    do_reset();
    thr = 24'd3000; en = 1'b1;
    for (int i = 0; i < 8; i++) xact(24'(ncons_seq[i]), 5, 1'b0, 1'b0);
    chk("noncons", alarm, 0);

    // timeout, clear, and clear coincident with a new timeout
    do_reset();
    thr = '0; en = 1'b1;
    wait_fetch(40, f);
    repeat (TMO - 1) @(negedge clk);
    chk("fault_early", fault, 0);
    @(negedge clk);
    chk("fault_at_32", fault, 1);
    chk("to_no_vld", svld, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    chk("fault_clr", fault, 0);
    wait_fetch(40, f);
    repeat (TMO - 1) @(negedge clk);
    clr = 1'b1;
    chk("fault_pre", fault, 0);
    @(negedge clk);
    clr = 1'b0;
    chk("fault_set_wins", fault, 1);
    @(negedge clk);
    chk("fault_sticky", fault, 1);
    chk("to_alarm", alarm, 0);

    // busy sensor spanning two ticks, plus a stray strobe while idle
    do_reset();
    en = 1'b1; rdy = 1'b0;
    count_fetch(20, c1);
    arr = 1'b1; acc = 24'h123456;
    @(negedge clk);
    arr = 1'b0;
    chk("stray_vld", svld, 0);
    chk("stray_smp", smp,  0);
    count_fetch(19, c2);
    chk("busy_nofetch", c1 + c2, 0);
    rdy = 1'b1;
    count_fetch(6, c);
    chk("busy_onefetch", c, 1);

    // enable drop during WAIT
    do_reset();
    thr = 24'd1000; en = 1'b1;
    xact(24'd0,      3, 1'b0, 1'b0);
    xact(24'd100000, 3, 1'b0, 1'b0);
    xact(24'd0,      3, 1'b0, 1'b1);
    model_flush();
    count_fetch(40, c);
    chk("drop_nofetch", c, 0);
    en = 1'b1;
    xact(24'd100000, 3, 1'b0, 1'b0);
    chk("reen_no_alarm", alarm, 0);
    xact(24'd0,      3, 1'b0, 1'b0);
    xact(24'd100000, 3, 1'b0, 1'b0);
    xact(24'd0,      3, 1'b0, 1'b0);
    chk("reen_alarm", alarm, 1);

    // randomized traffic
    do_reset();
    en = 1'b1;
    thr = 24'($urandom_range(0, 24'h7FFFFF));
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 7) == 0) thr = 24'($urandom_range(0, 24'h7FFFFF));
      xact(24'($urandom), int'($urandom_range(0, 10)), ($urandom_range(0, 5) == 0), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
